// File: rtl/dbus_mem_resp.sv
// Data-bus memory responder: one load/store at a time into a local byte-enabled word memory.
// Latency: ack_o in cycle W+1 after the sampling edge (W = WAIT_CYCLES with DBUS_RESP_WAIT_EN, else 0).
// Backpressure: req_i is held by the requester until ack_o; busy_o is high while a transaction is in flight.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   req_i, w_en_i       request valid (held until ack), 1 = store / 0 = load
//   addr_i, wdata_i     byte address (bits [1:0] ignored), lane-aligned store data
//   sel_byte_i          store byte enables (ignored for loads)
//   flush_i             abandons a transaction that has not yet committed
//   ack_o, rdata_o      one-cycle acknowledge; load data, zero whenever ack_o is low
//   busy_o              high in any state other than IDLE
//
// Optional feature macro: DBUS_RESP_WAIT_EN builds the WAIT state and 4-bit wait counter.
module dbus_mem_resp #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        w_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_byte_i,
    input  logic        flush_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef DBUS_RESP_WAIT_EN
        S_WAIT = 2'd1,
`endif
        S_ACK  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured request; addresses are kept as word addresses.
    logic        req_we_q,    req_we_d;
    logic [29:0] req_addr_q,  req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_sel_q,   req_sel_d;

    // Set on the commit edge of an in-range load; qualifies the RAM read data in ACK.
    logic        rd_hit_q, rd_hit_d;

`ifdef DBUS_RESP_WAIT_EN
    logic [3:0]  cnt_q, cnt_d;
`else
    logic        unused_cfg;
    assign unused_cfg = &{1'b0, 4'(WAIT_CYCLES)};
`endif

    logic        unused_addr;
    assign unused_addr = &{1'b0, addr_i[1:0]};

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] mem_rd_q;

    // The commit edge can be the sampling edge itself (W=0), so the access
    // uses the live inputs in IDLE and the captured copy otherwise.
    logic                  commit;
    logic                  cur_we;
    logic [29:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_sel;
    logic                  cur_in_range;
    logic [ADDR_WIDTH-1:0] cur_idx;

    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = w_en_i;
            cur_addr  = addr_i[31:2];
            cur_wdata = wdata_i;
            cur_sel   = sel_byte_i;
        end else begin
            cur_we    = req_we_q;
            cur_addr  = req_addr_q;
            cur_wdata = req_wdata_q;
            cur_sel   = req_sel_q;
        end
    end

    assign cur_in_range = (cur_addr[29:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign cur_idx      = cur_addr[ADDR_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_sel_d   = req_sel_q;
        commit      = 1'b0;
`ifdef DBUS_RESP_WAIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A flush in the same cycle as the request refuses it.
                if (req_i && !flush_i) begin
                    req_we_d    = w_en_i;
                    req_addr_d  = addr_i[31:2];
                    req_wdata_d = wdata_i;
                    req_sel_d   = sel_byte_i;
`ifdef DBUS_RESP_WAIT_EN
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
`else
                    state_d = S_ACK;
                    commit  = 1'b1;
`endif
                end
            end
`ifdef DBUS_RESP_WAIT_EN
            S_WAIT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
`endif
            S_ACK: begin
                // Already committed: req_i and flush_i are ignored here.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        rd_hit_d = commit && !cur_we && cur_in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_sel_q   <= '0;
            rd_hit_q    <= 1'b0;
`ifdef DBUS_RESP_WAIT_EN
            cnt_q       <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_sel_q   <= req_sel_d;
            rd_hit_q    <= rd_hit_d;
`ifdef DBUS_RESP_WAIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // RAM port: no reset on contents. Gating with rst makes reset win over a
    // coincident commit edge.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            if (cur_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (cur_in_range && cur_sel[i]) begin
                        mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                    end
                end
            end else begin
                mem_rd_q <= mem[cur_idx];
            end
        end
    end

    assign ack_o   = (state_q == S_ACK);
    assign busy_o  = (state_q != S_IDLE);
    assign rdata_o = (ack_o && rd_hit_q) ? mem_rd_q : 32'h0;

endmodule
